freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//   Measures the frequency of an external square-wave input, such as a tone
//   or a key line, against the system clock. Rising edges are counted over a
//   fixed gate window of GATE_CYCLES clocks.
//   Each window's result is published with a one-cycle valid strobe.
//   It is the measuring counterpart of the free-running clock divider and sits
//   beside it in the audio path, feeding tone verification and display logic.
// PARAMETERS
//   GATE_CYCLES  100_000_000  gate window length in clk cycles (>=2); default gives a 1 s window at 100 MHz
//   CNT_W        32           width of the edge count / result
//   SYNC_STAGES  2            synchronizer flops on sig_in (>=2)
// PORTS
//   clk         in   1      system clock; all logic on its rising edge
//   rst         in   1      synchronous, active-high reset
//   en          in   1      measurement enable (level)
//   sig_in      in   1      asynchronous signal under measurement
//   freq        out  CNT_W  edge count of last completed window (held)
//   freq_valid  out  1      1-cycle pulse when freq is updated
//   overflow    out  1      last completed window saturated; updated with freq
//   busy        out  1      high while a window is in progress
// BEHAVIOUR
//   - Reset (rst=1 at clk edge):
//     - state=IDLE; freq=0, freq_valid=0, overflow=0, busy=0.
//     - Sync chain, prev flop and all counters are cleared to 0.
//     - rst wins over every other event, including mid-window; the partial window is discarded.
//   - Sync/edge detection:
//     - sig_in passes through SYNC_STAGES flops, then one prev flop.
//     - edge = sync_out & ~prev.
//     - These flops run in every state, so an input already high when en rises is not counted.
//     - Minimum countable high or low time is 1 clk. Maximum countable rate is one edge per 2 clks.
//   - FSM, 2 states:
//     - IDLE:
//       - busy=0.
//       - On en=1 -> RUN, with gate_cnt=0 and edge_cnt=0.
//       - Edges seen in IDLE are ignored.
//     - RUN:
//       - busy=1. gate_cnt increments each cycle.
//       - edge_cnt increments on edge, saturating at 2^CNT_W-1.
//       - A sat flag is set if an increment is attempted at the max value.
//   - Window close:
//     - The window closes on the RUN cycle with gate_cnt==GATE_CYCLES-1 and en=1.
//     - At that clk edge: freq <= edge_cnt + edge (saturated); overflow <= sat or saturation now.
//     - At the same edge: freq_valid <= 1; gate_cnt, edge_cnt and sat are cleared.
//     - The state stays RUN, so the next window starts back-to-back with no gap cycle.
//     - An edge on the closing cycle belongs to the closing window.
//   - en=0 in RUN:
//     - At the next edge -> IDLE. The window is abandoned and no freq_valid is raised.
//     - freq and overflow hold their last published values.
//   - Timing:
//     - A window is exactly GATE_CYCLES RUN cycles.
//     - The first freq_valid comes GATE_CYCLES+1 clk edges after the edge that samples en=1.
//     - It then repeats every GATE_CYCLES cycles.
//   - freq_valid is high for exactly one cycle per completed window and is 0 otherwise.
//   - Widths: gate_cnt is $clog2(GATE_CYCLES) bits; no arithmetic wraps (saturating only).
// STRUCTURE
//   - Shared package melody_pkg: CLK_HZ (100_000_000) and DIV_W (32), used as defaults here and by the divider.
//   - The FSM state encoding is a localparam, private to this file.
//   - One sub-module: sync_edge_det (param STAGES; ports clk, rst, d, q, rise), reusable for key inputs.
//   - Counters and FSM stay in freq_meter.
// TESTING (GATE_CYCLES=16, CNT_W=8 unless noted)
//   1. Reset: hold rst 3 cycles with sig_in toggling -> freq=0, freq_valid=0, overflow=0, busy=0 throughout.
//   2. sig_in period 4 clks, en=1 continuously -> freq_valid pulses every 16 cycles, first at edge 17.
//      Each pulse gives freq=4, overflow=0.
//   3. CNT_W=3, sig_in period 2 (8 edges/window) -> freq=7, overflow=1 with each valid.
//      Then period 4 -> freq=4, overflow=0.
//   4. Complete one window (freq=4), then drop en at RUN cycle 10 -> busy=0 next cycle, no valid, freq stays 4.
//      Re-raise en -> a fresh 16-cycle window, valid with freq=4.
//   5. sig_in held high before en rises, held for the whole window -> freq=0.
//      A single 1-clk-high pulse placed on the closing cycle (after sync delay) -> freq=1.
//   6. rst asserted at RUN cycle 8 -> next cycle all outputs 0, state IDLE.
//      No freq_valid until a full window after en is re-sampled.

Source files
------------

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module   : melody_pkg
// Brief    : Shared constants for the audio/melody path (divider, meter).
// Revision : 1.0
// ============================================================================
package melody_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int DIV_W  = 32;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Multi-flop synchronizer with rising-edge detect on its output.
// Revision : 1.0
// ============================================================================
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_ff;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
            prev    <= sync_ff[STAGES-1];
        end
    end

    assign q    = sync_ff[STAGES-1];
    assign rise = q & ~prev;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Brief    : Counts rising edges of an async input over back-to-back gate windows.
// Revision : 1.0
// ============================================================================
module freq_meter
    import melody_pkg::*;
#(
    parameter int GATE_CYCLES = CLK_HZ,
    parameter int CNT_W       = DIV_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              win_start;
    logic              win_close;

    logic [GATE_W-1:0] gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_nxt;
    logic              sat;
    logic              sat_now;
    logic              sig_sync;
    logic              sig_rise;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .q    (sig_sync),
        .rise (sig_rise)
    );

    // Saturating edge count including the edge seen this cycle
    assign sat_now  = sig_rise & (edge_cnt == CNT_MAX);
    assign edge_nxt = (sig_rise && !sat_now) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_start = 1'b0;
        win_close = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                    win_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (gate_cnt == GATE_LAST) begin
                    win_close = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Closing a window restarts the counters in place: the next window
    // begins on the very next cycle without leaving RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (win_start) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (win_close) begin
                freq       <= edge_nxt;
                overflow   <= sat | sat_now;
                freq_valid <= 1'b1;
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                sat        <= 1'b0;
            end else if (state == ST_RUN) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_nxt;
                sat      <= sat | sat_now;
            end
        end
    end

    assign busy = (state == ST_RUN);

    // The synchronized level itself is not needed here, only its edges
    logic unused_ok;
    assign unused_ok = sig_sync;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Brief    : Self-checking bench: window/edge model vs. two meter instances.
// Revision : 1.0
// ============================================================================
module tb_freq_meter;

    localparam int G  = 16;
    localparam int S  = 2;
    localparam int HN = 16384;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sig_in = 1'b0;
    logic [7:0] freq8;
    logic       fv8, ov8, busy8;
    logic [2:0] freq3;
    logic       fv3, ov3, busy3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(S)) u8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq8), .freq_valid(fv8), .overflow(ov8), .busy(busy8)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(3), .SYNC_STAGES(S)) u3 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq(freq3), .freq_valid(fv3), .overflow(ov3), .busy(busy3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sampled input history per clock edge; a window's result is the number
    // of synchronized 0->1 transitions over its GATE_CYCLES edges.
    bit  hist [0:HN-1];
    int  m = 0;
    int  zero_upto = 0;
    bit  running = 0;
    int  start = 0;
    int  e_f8 = 0, e_f3 = 0;
    bit  e_o8 = 0, e_o3 = 0, e_valid = 0, e_busy = 0;

    function automatic int sval(input int n);
        if (n <= zero_upto || n < 0) return 0;
        return int'(hist[n]);
    endfunction

    function automatic int rise_at(input int n);
        return (sval(n - S) == 1 && sval(n - S - 1) == 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int sum;
        m++;
        if (m >= HN) begin
            $display("FAIL hist_bound: got %0d expected below %0d", m, HN);
            $fatal(1, "history exhausted");
        end
        hist[m] = sig_in;
        e_valid = 0;
        if (rst) begin
            zero_upto = m;
            running = 0;
            e_f8 = 0; e_o8 = 0; e_f3 = 0; e_o3 = 0;
        end else if (!running) begin
            if (en) begin
                running = 1;
                start = m;
            end
        end else if (!en) begin
            running = 0;
        end else if (m - start == G) begin
            sum = 0;
            for (int j = start + 1; j <= m; j++) sum += rise_at(j);
            e_f8 = (sum > 255) ? 255 : sum;
            e_o8 = (sum > 255);
            e_f3 = (sum > 7) ? 7 : sum;
            e_o3 = (sum > 7);
            e_valid = 1;
            start = m;
        end
        e_busy = running;
    end

    always @(negedge clk) begin
        if (m > 0) begin
            chk("freq8", freq8, e_f8);
            chk("valid8", fv8, e_valid);
            chk("ovf8", ov8, e_o8);
            chk("busy8", busy8, e_busy);
            chk("freq3", freq3, e_f3);
            chk("valid3", fv3, e_valid);
            chk("ovf3", ov3, e_o3);
            chk("busy3", busy3, e_busy);
        end
    end

    // ---------------- stimulus ----------------
    int mode = 2;   // 0 hold, 1 periodic, 2 random
    int period = 4;
    int ph = 0;

    task automatic step();
        @(posedge clk);
        #1;
        case (mode)
            1: begin
                ph = (ph + 1) % period;
                sig_in = (ph < period / 2);
            end
            2: sig_in = $urandom_range(0, 1);
            default: ;
        endcase
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            @(negedge clk);
            if (fv8 === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL valid_timeout: got none expected pulse within %0d cycles", budget);
        end
    endtask

    initial begin
        int cyc;
        int npulse;
        int fv_at;

        // 1. reset with toggling input
        mode = 2;
        steps(3);
        @(negedge clk);
        chk("rst_freq", freq8, 0);
        chk("rst_valid", fv8, 0);
        chk("rst_ovf", ov8, 0);
        chk("rst_busy", busy8, 0);

        // 2. period 4, continuous enable
        rst = 1'b0;
        mode = 1; period = 4; ph = 0;
        steps(3);
        en = 1'b1;
        wait_valid(40, cyc);
        chk("first_latency", cyc, 17);
        chk("p4_freq", freq8, 4);
        chk("p4_ovf", ov8, 0);
        wait_valid(40, cyc);
        chk("repeat_latency", cyc, 16);
        chk("p4_freq_b", freq8, 4);

        // 3. saturation on the narrow instance
        period = 2; ph = 0;
        wait_valid(40, cyc);
        wait_valid(40, cyc);
        chk("p2_freq3", freq3, 7);
        chk("p2_ovf3", ov3, 1);
        chk("p2_freq8", freq8, 8);
        period = 4; ph = 0;
        wait_valid(40, cyc);
        wait_valid(40, cyc);
        chk("p4_freq3", freq3, 4);
        chk("p4_ovf3", ov3, 0);

        // 4. abandon a window at RUN cycle 10
        steps(10);
        en = 1'b0;
        step();
        @(negedge clk);
        chk("abandon_busy", busy8, 0);
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (fv8 === 1'b1) npulse++;
        end
        chk("abandon_pulses", npulse, 0);
        chk("abandon_hold", freq8, 4);
        en = 1'b1;
        wait_valid(40, cyc);
        chk("reenable_latency", cyc, 17);
        chk("reenable_freq", freq8, 4);

        // 5. input high before enable, then a lone pulse on the closing cycle
        en = 1'b0;
        mode = 0; sig_in = 1'b1;
        steps(5);
        en = 1'b1;
        wait_valid(40, cyc);
        chk("high_freq", freq8, 0);
        en = 1'b0;
        steps(3);
        sig_in = 1'b0;
        steps(4);
        en = 1'b1;
        fv_at = -1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 14) sig_in = 1'b1;
            if (k == 15) sig_in = 1'b0;
            @(negedge clk);
            if (fv8 === 1'b1 && fv_at < 0) fv_at = k;
        end
        chk("pulse_valid_at", fv_at, 17);
        chk("pulse_freq", freq8, 1);

        // 6. reset mid-window
        mode = 1; period = 4; ph = 0;
        steps(8);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", busy8, 0);
        chk("midrst_freq", freq8, 0);
        chk("midrst_ovf", ov8, 0);
        rst = 1'b0;
        wait_valid(40, cyc);
        chk("postrst_latency", cyc, 17);

        // randomized input, enable drops and occasional resets
        mode = 2;
        for (int i = 0; i < 600; i++) begin
            step();
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 249) == 0);
        end
        rst = 1'b0;
        en = 1'b1;
        steps(40);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
